spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 29 ++
 rtl/spi_sync.sv | 32 +++
 rtl/spi_slave.sv | 173 +++++++++++++++++
 tb/tb_spi_slave.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI mode-0 slave: state encoding, frame width
// and the default synchronizer depth.
package spi_slave_pkg;

  // Controller states; the encoding is fixed so spi_idle decodes a single bit.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Bits per SPI frame.
  localparam int FRAME_W = 8;

  // Width of the in-frame bit counter.
  localparam int BIT_CNT_W = $clog2(FRAME_W);

  // Default number of synchronizer flops on the SPI inputs.
  localparam int SYNC_STAGES_DEF = 2;

  // Bundle layout of the synchronized SPI inputs {spi_clk, spi_cs_n, spi_mosi}.
  localparam int SYNC_W    = 3;
  localparam int IDX_SCLK  = 2;
  localparam int IDX_CS_N  = 1;
  localparam int IDX_MOSI  = 0;

  // Synchronizer reset value: spi_clk idle low, chip select deasserted.
  localparam logic [SYNC_W-1:0] SYNC_RST_VAL = 3'b010;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous single-bit inputs.
// Each bit is synchronized independently; DEPTH is the number of flops.
module spi_sync #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the asynchronous inputs through DEPTH flops; reset to a known idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_sync = r_stage[DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, 8-bit frames, MSB first, oversampled by the system clock.
// Optional feature: define SPI_SLAVE_MISO_OE_EN to add the spi_miso_oe output
// (high while ACTIVE) for driving a tristate MISO pad.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] din,
  input  logic               wr_sd,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] dout,
  input  logic               spi_clk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spi_done_tick,
  output logic               spi_idle
`ifdef SPI_SLAVE_MISO_OE_EN
  ,
  output logic               spi_miso_oe
`endif
);

  // Synchronized SPI inputs and edge-detect history.
  logic [SYNC_W-1:0]    w_sync;
  logic                 w_sclk_s;
  logic                 w_cs_s;
  logic                 w_mosi_s;
  logic                 r_sclk_d;
  logic                 r_cs_d;
  logic                 w_sclk_rise;
  logic                 w_sclk_fall;
  logic                 w_cs_fall;
  logic                 w_cs_rise;

  // Controller state.
  state_t               r_state;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [FRAME_W-1:0]   r_rx_sh;
  logic [FRAME_W-1:0]   r_tx_sh;
  logic [FRAME_W-1:0]   r_dout;
  logic                 r_done_tick;

  // Transmit holding register.
  logic [FRAME_W-1:0]   r_hold;
  logic                 r_pending;

  // Reload / write-accept decode.
  logic                 w_last_bit;
  logic                 w_load;
  logic                 w_accept;
  logic [FRAME_W-1:0]   w_reload_val;

  spi_sync #(
    .WIDTH   (SYNC_W),
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (SYNC_RST_VAL)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async ({spi_clk, spi_cs_n, spi_mosi}),
    .o_sync  (w_sync)
  );

  assign w_sclk_s = w_sync[IDX_SCLK];
  assign w_cs_s   = w_sync[IDX_CS_N];
  assign w_mosi_s = w_sync[IDX_MOSI];

  // One extra flop on synchronized clock and select for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_d   <= w_cs_s;
    end
  end

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;

  // A byte completes on the rising edge that samples its last bit; a chip
  // select rising edge on the same cycle wins and aborts instead.
  assign w_last_bit = (r_state == ST_ACTIVE) && !w_cs_rise && w_sclk_rise &&
                      (r_bit_cnt == BIT_CNT_W'(FRAME_W - 1));

  // The shifter reloads at frame start and at every byte boundary.
  assign w_load = ((r_state == ST_IDLE) && w_cs_fall) || w_last_bit;

  // Pending data goes out next; with nothing pending the master reads zeros.
  assign w_reload_val = r_pending ? r_hold : '0;

  // Writes are only taken while the holding register is empty. A write that
  // coincides with a reload from empty becomes pending for the following byte.
  assign w_accept = wr_sd & ~r_pending;

  // Holding register: capture accepted writes, release on reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold    <= din;
        r_pending <= 1'b1;
      end else if (w_load && r_pending) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Main FSM: frame tracking, receive/transmit shifting and byte completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_dout      <= '0;
      r_done_tick <= 1'b0;
    end else begin
      r_done_tick <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Clock edges are ignored until chip select is asserted.
          if (w_cs_fall) begin
            r_state   <= ST_ACTIVE;
            r_bit_cnt <= '0;
            r_tx_sh   <= w_reload_val;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            // Partial byte is dropped; dout and the holding register stay.
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
          end else if (w_sclk_rise) begin
            r_rx_sh   <= {r_rx_sh[FRAME_W-2:0], w_mosi_s};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last_bit) begin
              r_dout      <= {r_rx_sh[FRAME_W-2:0], w_mosi_s};
              r_done_tick <= 1'b1;
              r_tx_sh     <= w_reload_val;
            end
          end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
            // At bit 0 the freshly loaded MSB must stay on the line.
            r_tx_sh <= {r_tx_sh[FRAME_W-2:0], 1'b0};
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout          = r_dout;
  assign spi_done_tick = r_done_tick;
  assign spi_idle      = (r_state == ST_IDLE);
  assign tx_ready      = ~r_pending;
  assign spi_miso      = (r_state == ST_ACTIVE) ? r_tx_sh[FRAME_W-1] : 1'b0;

`ifdef SPI_SLAVE_MISO_OE_EN
  assign spi_miso_oe   = (r_state == ST_ACTIVE);
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios plus randomized
// frames, checked by scoreboard queues fed from a transaction-level model.
// Honours SPI_SLAVE_MISO_OE_EN when defined.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr_sd = 1'b0;
  logic       tx_ready;
  logic [7:0] dout;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_done_tick;
  logic       spi_idle;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic       spi_miso_oe;
`endif

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .din           (din),
    .wr_sd         (wr_sd),
    .tx_ready      (tx_ready),
    .dout          (dout),
    .spi_clk       (spi_clk),
    .spi_cs_n      (spi_cs_n),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_done_tick (spi_done_tick),
    .spi_idle      (spi_idle)
`ifdef SPI_SLAVE_MISO_OE_EN
    ,
    .spi_miso_oe   (spi_miso_oe)
`endif
  );

  int tests = 0;
  int fails = 0;
  int tick_count = 0;

  // Scoreboard queues: expected received bytes and expected transmitted bytes.
  logic [7:0] q_dout[$];
  logic [7:0] q_miso[$];

  // Transaction-level model of the transmit holding register and dout.
  bit         m_pending = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] m_dout = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Next byte presented to the master: the pending write if any, else zero.
  function automatic logic [7:0] m_reload();
    logic [7:0] v;
    if (m_pending) begin
      m_pending = 1'b0;
      v = m_hold;
    end else begin
      v = 8'h00;
    end
    return v;
  endfunction

  // Monitor: every done tick pops one expected received byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset && spi_done_tick) begin
      tick_count++;
      if (q_dout.size() == 0) begin
        check("unexpected_tick", 32'd1, 32'd0);
      end else begin
        e = q_dout.pop_front();
        check("dout", {24'd0, dout}, {24'd0, e});
        $display("[TB] rx byte dout=%02h expected=%02h", dout, e);
      end
    end
  end

  // Monitor: master-side MISO capture on each SCLK rising edge.
  int         mcnt = 0;
  logic [7:0] msh = 8'h00;
  always @(posedge spi_clk or posedge spi_cs_n or posedge reset) begin
    logic [7:0] e;
    if (spi_cs_n || reset) begin
      mcnt = 0;
    end else begin
      msh = {msh[6:0], spi_miso};
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        if (q_miso.size() == 0) begin
          check("unexpected_miso", 32'd1, 32'd0);
        end else begin
          e = q_miso.pop_front();
          check("miso", {24'd0, msh}, {24'd0, e});
          $display("[TB] tx byte miso=%02h expected=%02h", msh, e);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    wr_sd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_pending = 1'b0;
    m_dout = 8'h00;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, {24'd0, dout}, 32'h00);
    check({tag, "_tick"}, {31'd0, spi_done_tick}, 32'd0);
    check({tag, "_idle"}, {31'd0, spi_idle}, 32'd1);
    check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd0);
`endif
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    din = b;
    wr_sd = 1'b1;
    @(negedge clk);
    wr_sd = 1'b0;
    if (!m_pending) begin
      m_pending = 1'b1;
      m_hold = b;
    end
    check("tx_ready", {31'd0, tx_ready}, {31'd0, !m_pending});
    $display("[TB] write din=%02h tx_ready=%0b", b, tx_ready);
  endtask

  // One chip-select frame of nbits bits; byte k is data[8k +: 8], MSB first.
  task automatic run_frame(input int nbits, input logic [31:0] data);
    logic [7:0] cur;
    int k;
    int b;
    @(negedge clk);
    spi_cs_n = 1'b0;
    cur = m_reload();
    repeat (6) @(negedge clk);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("oe_active", {31'd0, spi_miso_oe}, 32'd1);
`endif
    for (int i = 0; i < nbits; i++) begin
      k = i / 8;
      b = 7 - (i % 8);
      spi_mosi = data[8*k + b];
      repeat (4) @(negedge clk);
      if (i % 8 == 7) begin
        q_dout.push_back(data[8*k +: 8]);
        m_dout = data[8*k +: 8];
        q_miso.push_back(cur);
        cur = m_reload();
      end
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    $display("[TB] frame bits=%0d data=%08h dout=%02h idle=%0b", nbits, data, dout, spi_idle);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [31:0] d;
    int nbytes;
    int nbits;

    // Reset state.
    do_reset();
    check_reset_outputs("reset");

    // Preloaded byte out, 0x3C in.
    write_byte(8'hA5);
    check("preload_not_ready", {31'd0, tx_ready}, 32'd0);
    t0 = tick_count;
    run_frame(8, 32'h0000_003C);
    check("one_tick", tick_count - t0, 32'd1);
    check("ready_after", {31'd0, tx_ready}, 32'd1);
    check("dout_3c", {24'd0, dout}, 32'h3C);

    // Two-byte frame with nothing preloaded.
    t0 = tick_count;
    run_frame(16, 32'h0000_FF01);
    check("two_ticks", tick_count - t0, 32'd2);
    check("dout_ff", {24'd0, dout}, 32'hFF);

    // Aborted frame after 5 bits.
    do_reset();
    t0 = tick_count;
    run_frame(5, 32'h0000_00FF);
    check("abort_no_tick", tick_count - t0, 32'd0);
    check("abort_dout", {24'd0, dout}, 32'h00);
    check("abort_idle", {31'd0, spi_idle}, 32'd1);

    // Second write while full is ignored.
    write_byte(8'h11);
    write_byte(8'h22);
    run_frame(8, 32'h0000_0077);

    // Reset during bit 3 of a frame carrying a preloaded byte.
    write_byte(8'h5A);
    @(negedge clk);
    spi_cs_n = 1'b0;
    void'(m_reload());
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = i[0];
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
    do_reset();
    check_reset_outputs("midreset");
    run_frame(8, 32'h0000_0096);
    check("post_reset_dout", {24'd0, dout}, 32'h96);

    // Randomized frames against the model.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) write_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) write_byte(8'($urandom));
      nbytes = $urandom_range(1, 3);
      nbits = 8 * nbytes;
      if ($urandom_range(0, 3) == 0) nbits = 8 * (nbytes - 1) + $urandom_range(1, 7);
      d = $urandom;
      t0 = tick_count;
      run_frame(nbits, d);
      check("rand_ticks", tick_count - t0, nbits / 8);
      check("rand_dout", {24'd0, dout}, {24'd0, m_dout});
      check("rand_idle", {31'd0, spi_idle}, 32'd1);
      check("rand_tx_ready", {31'd0, tx_ready}, {31'd0, !m_pending});
    end

    check("queues_drained", q_dout.size() + q_miso.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
